// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if
//   Groups the serial-side inputs and parallel-side outputs of uart_rx_ctrl.
//   Signal names are prefixed from the receiver's point of view.
//   master : line/baud side; drives i_rx, i_sample_tick and observes the results
//   slave  : the receiver (uart_rx_ctrl)
//   i_rx           serial line, idle high, already synchronised
//   i_sample_tick  one-clk enable, OVERSAMPLE per bit period
//   o_rx_data      last good word
//   o_rx_valid     one-cycle pulse, o_rx_data updated
//   o_frame_error  one-cycle pulse, stop bit sampled low
//   o_parity_error one-cycle pulse alongside o_rx_valid on parity mismatch
//   o_busy         high whenever the receiver is not idle
interface uart_rx_ctrl_if #(
   parameter int unsigned DATA_BITS = 8
);
   logic                 i_rx;
   logic                 i_sample_tick;
   logic [DATA_BITS-1:0] o_rx_data;
   logic                 o_rx_valid;
   logic                 o_frame_error;
   logic                 o_parity_error;
   logic                 o_busy;

   modport master (
      output i_rx, i_sample_tick,
      input  o_rx_data, o_rx_valid, o_frame_error, o_parity_error, o_busy
   );

   modport slave (
      input  i_rx, i_sample_tick,
      output o_rx_data, o_rx_valid, o_frame_error, o_parity_error, o_busy
   );
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
//   UART receive engine: FSM with integrated oversample tick counter, bit
//   counter and shift register. Samples the line at the middle of each bit,
//   validates the start bit, and reports each frame with one-cycle pulses.
//   Optional feature macro: UART_RX_PARITY_EN (adds one parity bit per frame,
//   checked as even or odd according to PARITY_ODD).
// Ports:
//   i_clk    clock
//   i_reset  synchronous, active-high reset
//   bus      uart_rx_ctrl_if.slave: i_rx, i_sample_tick in;
//            o_rx_data, o_rx_valid, o_frame_error, o_parity_error, o_busy out
module uart_rx_ctrl #(
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY_ODD = 0
) (
   input logic           i_clk,
   input logic           i_reset,
   uart_rx_ctrl_if.slave bus
);
   localparam int unsigned   TW        = $clog2(OVERSAMPLE);
   localparam int unsigned   BW        = $clog2(DATA_BITS);
   localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

   if ((OVERSAMPLE < 4) || ((OVERSAMPLE % 2) != 0)) begin : g_bad_oversample
      $error("uart_rx_ctrl: OVERSAMPLE must be even and >= 4");
   end
   if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data_bits
      $error("uart_rx_ctrl: DATA_BITS must be 5..9");
   end
   if (PARITY_ODD > 1) begin : g_bad_parity_odd
      $error("uart_rx_ctrl: PARITY_ODD must be 0 or 1");
   end

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
`ifdef UART_RX_PARITY_EN
      ST_PARITY,
`endif
      ST_STOP,
      ST_BRK
   } state_t;

   state_t               r_state;
   logic [TW-1:0]        r_tick_cnt;
   logic [BW-1:0]        r_bit_cnt;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] r_rx_data;
   logic                 r_rx_valid;
   logic                 r_frame_error;
   logic                 r_busy;
`ifdef UART_RX_PARITY_EN
   logic                 r_par_err;
   logic                 r_parity_error;
`endif

   logic w_rx;
   logic w_tick;

   assign w_rx   = bus.i_rx;
   assign w_tick = bus.i_sample_tick;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state       <= ST_IDLE;
         r_tick_cnt    <= '0;
         r_bit_cnt     <= '0;
         r_shift       <= '0;
         r_rx_data     <= '0;
         r_rx_valid    <= 1'b0;
         r_frame_error <= 1'b0;
         r_busy        <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_err      <= 1'b0;
         r_parity_error <= 1'b0;
`endif
      end else begin
         // Result pulses last exactly one clk regardless of tick spacing.
         r_rx_valid    <= 1'b0;
         r_frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_parity_error <= 1'b0;
`endif
         if (w_tick) begin
            case (r_state)
               ST_IDLE: begin
                  if (!w_rx) begin
                     r_state    <= ST_START;
                     r_tick_cnt <= '0;
                     r_busy     <= 1'b1;
                  end
               end

               ST_START: begin
                  if (r_tick_cnt == HALF_LAST) begin
                     if (w_rx) begin
                        // Line back high at mid start bit: glitch, not a frame.
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                     end else begin
                        r_state    <= ST_DATA;
                        r_tick_cnt <= '0;
                        r_bit_cnt  <= '0;
                     end
                  end else begin
                     r_tick_cnt <= r_tick_cnt + TW'(1);
                  end
               end

               ST_DATA: begin
                  if (r_tick_cnt == BIT_LAST) begin
                     r_tick_cnt <= '0;
                     // LSB arrives first, so shift right and enter at the MSB.
                     r_shift    <= {w_rx, r_shift[DATA_BITS-1:1]};
                     if (r_bit_cnt == DATA_LAST) begin
`ifdef UART_RX_PARITY_EN
                        r_state <= ST_PARITY;
`else
                        r_state <= ST_STOP;
`endif
                     end else begin
                        r_bit_cnt <= r_bit_cnt + BW'(1);
                     end
                  end else begin
                     r_tick_cnt <= r_tick_cnt + TW'(1);
                  end
               end

`ifdef UART_RX_PARITY_EN
               ST_PARITY: begin
                  if (r_tick_cnt == BIT_LAST) begin
                     r_tick_cnt <= '0;
                     r_par_err  <= w_rx ^ (^r_shift) ^ 1'(PARITY_ODD);
                     r_state    <= ST_STOP;
                  end else begin
                     r_tick_cnt <= r_tick_cnt + TW'(1);
                  end
               end
`endif

               ST_STOP: begin
                  if (r_tick_cnt == BIT_LAST) begin
                     r_tick_cnt <= '0;
                     if (w_rx) begin
                        r_rx_data  <= r_shift;
                        r_rx_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        r_parity_error <= r_par_err;
`endif
                        r_state    <= ST_IDLE;
                        r_busy     <= 1'b0;
                     end else begin
                        r_frame_error <= 1'b1;
                        r_state       <= ST_BRK;
                     end
                  end else begin
                     r_tick_cnt <= r_tick_cnt + TW'(1);
                  end
               end

               ST_BRK: begin
                  // A held-low line must return high before a new start bit.
                  if (w_rx) begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                  end
               end

               default: begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.o_rx_data     = r_rx_data;
   assign bus.o_rx_valid    = r_rx_valid;
   assign bus.o_frame_error = r_frame_error;
   assign bus.o_busy        = r_busy;
`ifdef UART_RX_PARITY_EN
   assign bus.o_parity_error = r_parity_error;
`else
   assign bus.o_parity_error = 1'b0;
`endif
endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Parametrised UART receive engine: FSM plus integrated oversample tick counter, bit counter and shift register. It samples an already-synchronised serial line at the mid-point of each bit and validates the start bit. It delivers a parallel word with one-cycle valid, frame-error and (optionally) parity-error pulses. It sits between the baud-tick generator and the receive FIFO.

## Interface
- OVERSAMPLE, 16, sample ticks per bit; even, >= 4
- DATA_BITS, 8, data bits per frame; 5..9
- PARITY_ODD, 0, 0 = even parity, 1 = odd; used only with UART_RX_PARITY_EN
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- rx  in  1  serial line, idle high, pre-synchronised
- sample_tick  in  1  one-clk enable, OVERSAMPLE per bit period
- rx_data  out  DATA_BITS  last good word, LSB first on the line
- rx_valid  out  1  one-cycle pulse, rx_data updated
- frame_error  out  1  one-cycle pulse, stop bit sampled low
- parity_error  out  1  one-cycle pulse with rx_valid on parity mismatch
- busy  out  1  high whenever state != IDLE

## Operation
- Counters: tick_cnt is $clog2(OVERSAMPLE) bits; bit_cnt is $clog2(DATA_BITS) bits. Both change only on sample_tick.
- Without sample_tick, all state and counters hold.
- IDLE: on a tick with rx==0, go to START with tick_cnt=0.
- START: on each tick, if tick_cnt==OVERSAMPLE/2-1, evaluate rx; otherwise increment tick_cnt.
  - rx==1 is a false start: return to IDLE with no output.
  - rx==0: go to DATA with tick_cnt=0 and bit_cnt=0.
- DATA: on each tick, if tick_cnt==OVERSAMPLE-1, sample rx into shift MSB (shift right) and clear tick_cnt; otherwise increment tick_cnt.
  - After the sample, if bit_cnt==DATA_BITS-1, go to PARITY (macro set) or STOP; otherwise increment bit_cnt.
- PARITY: same tick rule; the sampled bit is checked against XOR of the shift register (inverted if PARITY_ODD); go to STOP.
- STOP: same tick rule. At the sample point:
  - rx==1: rx_data<=shift, rx_valid=1, parity_error=mismatch, go to IDLE.
  - rx==0: frame_error=1, rx_data unchanged, rx_valid=0, go to BRK.
- BRK: wait for a tick with rx==1, then go to IDLE. A held-low line (break) therefore never produces spurious frames.
- Reset (any cycle, including mid-frame): state IDLE, counters 0, shift 0, rx_data 0, rx_valid/frame_error/parity_error/busy 0.
- Reset has priority over every event.

## Timing
- All outputs are registered.
- Pulses are high for exactly one clk, in the cycle after the clk edge that consumed the stop-sample tick.
- Tick numbering: the IDLE tick that sees rx==0 is tick 0.
  - Start bit is evaluated at tick OVERSAMPLE/2.
  - Data bit i is sampled at tick OVERSAMPLE/2 + OVERSAMPLE*(i+1).
  - Stop bit is sampled at tick OVERSAMPLE/2 + OVERSAMPLE*(DATA_BITS+1+P), where P=1 with parity, else 0.
  - Example: 8N1 at 16x samples the stop bit at tick 152.
- busy rises in the cycle after tick 0. It falls in the same cycle rx_valid rises, or on exit from BRK / false start.
- A new frame may begin on the first tick after returning to IDLE; there is no dead time.
- A sample_tick asserted for consecutive clks counts as one tick per clk.

## Configuration
- UART_RX_PARITY_EN defined: the PARITY state exists; frames carry one parity bit after the data bits, checked per PARITY_ODD.
- UART_RX_PARITY_EN undefined: no PARITY state, parity_error is tied to 0, PARITY_ODD is ignored, and the frame is start + DATA_BITS + stop.

## Test plan
- Reset: hold reset 3 clks with rx toggling -> all outputs 0, busy 0; after release with rx high, nothing asserts for 200 ticks.
- 8N1 at 16x: send 0xA5 (LSB first) -> exactly one rx_valid pulse the clk after tick 152; rx_data=0xA5; frame_error=0; busy low in the same cycle.
- Glitch: rx low for ticks 0..3, then high -> no pulses; busy drops after tick 8; the following frame 0x3C is received correctly.
- Framing: send 0x3C with stop bit low, hold rx low 40 more ticks, then high -> one frame_error pulse; rx_valid 0; rx_data keeps its prior value; no frame starts until rx goes high; next frame 0x81 is received correctly.
- Parity (macro set, PARITY_ODD=0): send 0x07 with parity bit 1 -> rx_valid=1, parity_error=0. With parity bit 0 -> rx_valid=1 and parity_error=1 in the same cycle.
- Reset mid-frame and tick gaps: assert reset at tick 60 of a frame -> IDLE, no pulses. Then send 0x5A with sample_tick asserted every 3rd clk -> rx_data=0x5A, one rx_valid pulse.
